// File: rtl/ppu_background_fetch_sequencer.sv
// ppu_background_fetch_sequencer
// Sequences the four background VRAM reads for one tile (nametable,
// attribute, pattern low, pattern high) from loopy v, stages the returned
// bytes, and publishes a complete tile to the background shifters.
// Optional feature macro: PPU_BG_FETCH_ATTR_SELECT_EN -- when defined, the
// attribute output is reduced to the 2-bit quadrant palette selection.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | not fetching, address bus driven to 0
// NT     | nametable byte read (tile index)
// AT     | attribute byte read
// PT_LO  | pattern-table low bitplane read
// PT_HI  | pattern-table high bitplane read, coarse-X step
module ppu_background_fetch_sequencer #(
    parameter logic [13:0] NT_BASE          = 14'h2000,
    parameter logic [13:0] AT_OFFSET        = 14'h03C0,
    parameter int          CYCLES_PER_FETCH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_fetch_en,
    input  logic [14:0] i_v,
    input  logic        i_pattern_table_sel,
    input  logic [7:0]  i_data,
    output logic [13:0] o_address,
    output logic        o_read,
    output logic        o_inc_x,
    output logic        o_tile_valid,
    output logic [7:0]  o_nametable,
    output logic [7:0]  o_attribute,
    output logic [7:0]  o_pattern_lo,
    output logic [7:0]  o_pattern_hi
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NT    = 3'd1;
    localparam logic [2:0] S_AT    = 3'd2;
    localparam logic [2:0] S_PT_LO = 3'd3;
    localparam logic [2:0] S_PT_HI = 3'd4;

    // Phase counter runs down from CYCLES_PER_FETCH-1; zero marks the last cycle.
    localparam logic [1:0] PHASE_LOAD = 2'(CYCLES_PER_FETCH - 1);

    logic [2:0]  state;
    logic [1:0]  phase_cnt;
    logic        phase_first;
    logic        phase_last;
    logic        tile_done;
    logic [7:0]  nt_byte;
    logic [7:0]  at_byte;
    logic [7:0]  lo_stage;
    logic [7:0]  attr_next;
    logic [13:0] pt_address;

    // Phase boundary decode and tile completion (also the coarse-X strobe).
    always_comb begin
        phase_first = (state != S_IDLE) && (phase_cnt == PHASE_LOAD);
        phase_last  = (state != S_IDLE) && (phase_cnt == 2'd0);
        tile_done   = (state == S_PT_HI) && phase_last && i_fetch_en;
        o_read      = phase_first;
        o_inc_x     = tile_done;
    end

    // Fetch state machine; dropping i_fetch_en anywhere abandons the tile.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_IDLE;
            phase_cnt <= 2'd0;
        end else if (state == S_IDLE) begin
            if (i_fetch_en) begin
                state     <= S_NT;
                phase_cnt <= PHASE_LOAD;
            end
        end else if (!i_fetch_en) begin
            state     <= S_IDLE;
            phase_cnt <= 2'd0;
        end else if (phase_last) begin
            phase_cnt <= PHASE_LOAD;
            case (state)
                S_NT:    state <= S_AT;
                S_AT:    state <= S_PT_LO;
                S_PT_LO: state <= S_PT_HI;
                S_PT_HI: state <= S_NT;
                default: state <= S_IDLE;
            endcase
        end else begin
            phase_cnt <= phase_cnt - 2'd1;
        end
    end

`ifdef PPU_BG_FETCH_ATTR_SELECT_EN
    logic [1:0] quad;

    // Quadrant bits {v[6], v[1]} are frozen with the attribute byte so a
    // later scroll update cannot change the selection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            quad <= 2'd0;
        end else if (i_fetch_en && phase_last && (state == S_AT)) begin
            quad <= {i_v[6], i_v[1]};
        end
    end

    // Pick the 2-bit palette field for the tile's quadrant.
    always_comb begin
        attr_next = 8'h00;
        case (quad)
            2'd0:    attr_next[1:0] = at_byte[1:0];
            2'd1:    attr_next[1:0] = at_byte[3:2];
            2'd2:    attr_next[1:0] = at_byte[5:4];
            default: attr_next[1:0] = at_byte[7:6];
        endcase
    end
`else
    // Raw attribute byte; the consumer selects the quadrant.
    always_comb begin
        attr_next = at_byte;
    end
`endif

    // Stage the returned bytes at the edge that ends each phase.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            nt_byte  <= 8'h00;
            at_byte  <= 8'h00;
            lo_stage <= 8'h00;
        end else if (i_fetch_en && phase_last) begin
            case (state)
                S_NT:    nt_byte  <= i_data;
                S_AT:    at_byte  <= i_data;
                S_PT_LO: lo_stage <= i_data;
                default: ;
            endcase
        end
    end

    // Publish a finished tile; outputs hold until the next complete tile.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_tile_valid <= 1'b0;
            o_nametable  <= 8'h00;
            o_attribute  <= 8'h00;
            o_pattern_lo <= 8'h00;
            o_pattern_hi <= 8'h00;
        end else begin
            o_tile_valid <= tile_done;
            if (tile_done) begin
                o_nametable  <= nt_byte;
                o_attribute  <= attr_next;
                o_pattern_lo <= lo_stage;
                o_pattern_hi <= i_data;
            end
        end
    end

    // VRAM address for the current phase, 0 while idle.
    always_comb begin
        pt_address = {1'b0, i_pattern_table_sel, nt_byte, 1'b0, i_v[14:12]};
        o_address  = 14'h0000;
        case (state)
            S_NT:    o_address = NT_BASE | {2'b00, i_v[11:0]};
            S_AT:    o_address = NT_BASE | AT_OFFSET
                                 | {2'b00, i_v[11:10], 10'b0}
                                 | {8'b0, i_v[9:7], 3'b0}
                                 | {11'b0, i_v[4:2]};
            S_PT_LO: o_address = pt_address;
            S_PT_HI: o_address = pt_address | 14'h0008;
            default: o_address = 14'h0000;
        endcase
    end

endmodule

// File: tb/tb_ppu_background_fetch_sequencer.sv
// Directed bench for ppu_background_fetch_sequencer: reset, single tile,
// back-to-back tiles with coarse-X stepping, abort, mid-tile reset, and a
// second instance built with one cycle per fetch.
module tb_ppu_background_fetch_sequencer;

`ifdef PPU_BG_FETCH_ATTR_SELECT_EN
    localparam logic [7:0] EXP_ATTR = 8'h03;
`else
    localparam logic [7:0] EXP_ATTR = 8'hB4;
`endif

    logic        clk;
    logic        rst_n;
    logic        sel;

    logic        en;
    logic [14:0] v;
    logic [7:0]  data;
    logic [13:0] address;
    logic        read;
    logic        inc_x;
    logic        tile_valid;
    logic [7:0]  nametable;
    logic [7:0]  attribute;
    logic [7:0]  pattern_lo;
    logic [7:0]  pattern_hi;

    logic        en1;
    logic [14:0] v1;
    logic [7:0]  data1;
    logic [13:0] address1;
    logic        read1;
    logic        inc_x1;
    logic        tile_valid1;
    logic [7:0]  nametable1;
    logic [7:0]  attribute1;
    logic [7:0]  pattern_lo1;
    logic [7:0]  pattern_hi1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  tile_data [4];
    logic [13:0] tile_addr [4];

    ppu_background_fetch_sequencer dut (
        .i_clk               (clk),
        .i_reset_n           (rst_n),
        .i_fetch_en          (en),
        .i_v                 (v),
        .i_pattern_table_sel (sel),
        .i_data              (data),
        .o_address           (address),
        .o_read              (read),
        .o_inc_x             (inc_x),
        .o_tile_valid        (tile_valid),
        .o_nametable         (nametable),
        .o_attribute         (attribute),
        .o_pattern_lo        (pattern_lo),
        .o_pattern_hi        (pattern_hi)
    );

    ppu_background_fetch_sequencer #(.CYCLES_PER_FETCH(1)) dut1 (
        .i_clk               (clk),
        .i_reset_n           (rst_n),
        .i_fetch_en          (en1),
        .i_v                 (v1),
        .i_pattern_table_sel (sel),
        .i_data              (data1),
        .o_address           (address1),
        .o_read              (read1),
        .o_inc_x             (inc_x1),
        .o_tile_valid        (tile_valid1),
        .o_nametable         (nametable1),
        .o_attribute         (attribute1),
        .o_pattern_lo        (pattern_lo1),
        .o_pattern_hi        (pattern_hi1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  pos;
        int  k;
        int  incs;
        logic inc_seen;

        tile_data[0] = 8'h7A; tile_data[1] = 8'hB4;
        tile_data[2] = 8'h55; tile_data[3] = 8'hAA;
        tile_addr[0] = 14'h2C45; tile_addr[1] = 14'h2FC1;
        tile_addr[2] = 14'h17A2; tile_addr[3] = 14'h17AA;

        rst_n = 1'b0; sel = 1'b1;
        en = 1'b0; v = 15'h0; data = 8'h0;
        en1 = 1'b0; v1 = 15'h0; data1 = 8'h0;
        #2;
        check("rst_address", address, 0);
        check("rst_read", read, 0);
        check("rst_inc_x", inc_x, 0);
        check("rst_tile_valid", tile_valid, 0);
        check("rst_nametable", nametable, 0);
        check("rst_attribute", attribute, 0);
        check("rst_pattern_lo", pattern_lo, 0);
        check("rst_pattern_hi", pattern_hi, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // single tile
        v = 15'h2C45; en = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            data = tile_data[(c - 1) / 2];
            #1;
            check("tile_address", address, tile_addr[(c - 1) / 2]);
            check("tile_read", read, (c % 2) == 1);
            check("tile_inc_x", inc_x, c == 8);
            check("tile_valid_early", tile_valid, 0);
            tick();
        end
        #1;
        check("tile_valid_c9", tile_valid, 1);
        check("tile_nametable", nametable, 8'h7A);
        check("tile_attribute", attribute, EXP_ATTR);
        check("tile_pattern_lo", pattern_lo, 8'h55);
        check("tile_pattern_hi", pattern_hi, 8'hAA);
        en = 1'b0;
        tick();
        #1;
        check("idle_address", address, 0);
        check("idle_tile_valid", tile_valid, 0);

        // back-to-back tiles, bench steps coarse X on o_inc_x
        v = 15'h2C45; en = 1'b1; incs = 0;
        tick();
        for (int c = 1; c <= 34; c++) begin
            pos = (c - 1) % 8;
            k   = (c - 1) / 8;
            if (pos < 2)      data = 8'(8'h20 + k);
            else if (pos < 4) data = 8'hB4;
            else if (pos < 6) data = 8'(8'h30 + k);
            else              data = 8'(8'h40 + k);
            #1;
            check("b2b_read", read, (pos % 2) == 0);
            check("b2b_inc_x", inc_x, pos == 7);
            check("b2b_tile_valid", tile_valid, (c > 8) && (pos == 0));
            if (pos == 0) check("b2b_nt_address", address, 14'h2C45 + k);
            if (pos == 4) check("b2b_pt_address", address, 32'h1002 | ((32'h20 + k) << 4));
            if ((c > 8) && (pos == 0)) begin
                check("b2b_nametable", nametable, 8'h20 + k - 1);
                check("b2b_attribute", attribute, EXP_ATTR);
                check("b2b_pattern_lo", pattern_lo, 8'h30 + k - 1);
                check("b2b_pattern_hi", pattern_hi, 8'h40 + k - 1);
            end
            inc_seen = inc_x;
            if (inc_seen) incs++;
            if (c < 34) begin
                tick();
                if (inc_seen) v = v + 15'd1;
            end
        end
        check("b2b_inc_count", incs, 4);
        en = 1'b0;
        tick();
        #1;
        check("b2b_idle_address", address, 0);

        // abort on cycle 6
        v = 15'h2C45; en = 1'b1; data = 8'hEE;
        tick();
        for (int c = 1; c <= 5; c++) begin
            #1;
            check("abort_inc_x", inc_x, 0);
            check("abort_tile_valid", tile_valid, 0);
            tick();
        end
        en = 1'b0;
        #1;
        check("abort_inc_x_c6", inc_x, 0);
        tick();
        #1;
        check("abort_address_c7", address, 0);
        check("abort_read_c7", read, 0);
        for (int c = 0; c < 3; c++) begin
            check("abort_no_valid", tile_valid, 0);
            check("abort_no_inc", inc_x, 0);
            tick();
        end
        check("abort_nametable", nametable, 8'h23);
        check("abort_attribute", attribute, EXP_ATTR);
        check("abort_pattern_lo", pattern_lo, 8'h33);
        check("abort_pattern_hi", pattern_hi, 8'h43);

        // reset mid PT_LO
        en = 1'b1; data = 8'h66;
        tick();
        for (int c = 0; c < 4; c++) tick();
        check("rst_mid_pre_address", address, 14'h1662);
        rst_n = 1'b0;
        #1;
        check("rst_mid_address", address, 0);
        check("rst_mid_read", read, 0);
        check("rst_mid_inc_x", inc_x, 0);
        check("rst_mid_tile_valid", tile_valid, 0);
        check("rst_mid_nametable", nametable, 0);
        check("rst_mid_attribute", attribute, 0);
        check("rst_mid_pattern_lo", pattern_lo, 0);
        check("rst_mid_pattern_hi", pattern_hi, 0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("rst_post_address", address, 0);
        check("rst_post_read", read, 0);
        check("rst_post_tile_valid", tile_valid, 0);

        // one cycle per fetch
        v1 = 15'h2C45; en1 = 1'b1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            data1 = tile_data[c - 1];
            #1;
            check("cpf1_address", address1, tile_addr[c - 1]);
            check("cpf1_read", read1, 1);
            check("cpf1_inc_x", inc_x1, c == 4);
            check("cpf1_tile_valid_early", tile_valid1, 0);
            tick();
        end
        #1;
        check("cpf1_tile_valid_c5", tile_valid1, 1);
        check("cpf1_nametable", nametable1, 8'h7A);
        check("cpf1_attribute", attribute1, EXP_ATTR);
        check("cpf1_pattern_lo", pattern_lo1, 8'h55);
        check("cpf1_pattern_hi", pattern_hi1, 8'hAA);
        en1 = 1'b0;
        tick();
        #1;
        check("cpf1_idle_address", address1, 0);
        check("cpf1_idle_tile_valid", tile_valid1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ppu_background_fetch_sequencer.md
# ppu_background_fetch_sequencer

Generates the PPU background fetch sequence for one tile: nametable, attribute, pattern-low and pattern-high VRAM reads, driven from the loopy `v` register. It latches the returned bytes and presents a complete tile to the background shifters. It also issues the coarse-X increment strobe to the scroll register. It sits between the scroll/loopy register logic and the PPU VRAM bus arbiter, and is the parametrised, sequenced successor of the standalone attribute-address generator.

## Interface
- `NT_BASE`, 14'h2000: nametable base address.
- `AT_OFFSET`, 14'h03C0: attribute-table offset within a nametable.
- `CYCLES_PER_FETCH`, 2: clocks per memory access phase; legal values 1..4.
- `i_clk`  in  1  PPU clock (one dot per cycle).
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_fetch_en`  in  1  rendering enabled and inside a fetch window.
- `i_v`  in  15  loopy v (fine Y[14:12], NT[11:10], coarse Y[9:5], coarse X[4:0]).
- `i_pattern_table_sel`  in  1  PPUCTRL bit 4; background pattern table.
- `i_data`  in  8  VRAM read data.
- `o_address`  out  14  VRAM address.
- `o_read`  out  1  read strobe; first cycle of each phase.
- `o_inc_x`  out  1  coarse-X increment request; combinational, one cycle.
- `o_tile_valid`  out  1  registered one-cycle pulse; the tile outputs are new.
- `o_nametable`  out  8  latched tile index.
- `o_attribute`  out  8  attribute result (see Configuration).
- `o_pattern_lo`  out  8  latched pattern-low byte.
- `o_pattern_hi`  out  8  latched pattern-high byte.

## Operation
- States: IDLE, NT, AT, PT_LO, PT_HI.
- Each non-IDLE state lasts `CYCLES_PER_FETCH` cycles, counted by a phase counter of width clog2(4).
- IDLE to NT: on a clock edge with `i_fetch_en`=1.
- Each state advances to the next at the end of its last cycle.
- PT_HI to NT: when `i_fetch_en`=1 at the end of PT_HI, with no gap. Otherwise PT_HI goes to IDLE.
- Addresses (14-bit, OR-combined):
  - NT: `NT_BASE | v[11:0]`.
  - AT: `NT_BASE | AT_OFFSET | v[11:10]<<10 | v[9:7]<<3 | v[4:2]`.
  - PT_LO: `{sel, nt_byte, 1'b0, v[14:12]}`.
  - PT_HI: PT_LO address `| 8`.
- `nt_byte` is the value latched in NT; it is internal until the tile completes.
- `o_address` = 0 in IDLE.
- `i_data` is sampled at the edge that ends each phase, into an internal staging register.
- `{v[6], v[1]}` are captured at the end of AT.
- `o_inc_x` = 1 during the last cycle of PT_HI. The scroll register updates at that edge, so the following NT uses the new `v`.
- At the edge ending PT_HI, the staging registers transfer to the output registers, and `o_tile_valid` pulses in the next cycle.
- The output registers hold their values until the next complete tile.
- Abort: `i_fetch_en`=0 in any non-IDLE cycle forces IDLE at the next edge.
  - No `o_inc_x` or `o_tile_valid` is produced for the aborted tile, and the outputs keep their previous tile.
  - `o_inc_x` is gated by `i_fetch_en`.
- Reset: state IDLE, counter 0.
  - All outputs are 0: `o_address`, `o_read`, `o_inc_x`, `o_tile_valid`, and all data outputs.
  - Reset is honoured mid-tile without completing the tile.

## Timing
- With `CYCLES_PER_FETCH`=2: 8-cycle cadence, one tile every 8 dots, matching NES dots 1..8, 9..16, and so on.
- `o_read` is high on cycles 1, 3, 5, 7 of the tile.
- Data is sampled at the edges ending cycles 2, 4, 6, 8.
- `o_inc_x` is high on cycle 8; `o_tile_valid` is high on cycle 9, the first cycle of the next NT.
- Latency from the first NT cycle to `o_tile_valid` = 4×`CYCLES_PER_FETCH` cycles.
- With `CYCLES_PER_FETCH`=1, `o_read` is high on every non-IDLE cycle.

## Configuration
- `PPU_BG_FETCH_ATTR_SELECT_EN` defined: `o_attribute = {6'b0, (at_byte >> {v6, v1, 1'b0}) & 2'b11}`, i.e. the quadrant palette bits.
- Undefined: `o_attribute` is the raw attribute byte, and quadrant selection is the consumer's job. The `{v[6], v[1]}` capture logic is removed.

## Test plan
- **Reset:** assert `i_reset_n`=0 mid-PT_LO → all outputs 0 immediately; after release with `i_fetch_en`=0, stays IDLE with `o_address`=0.
- **Tile addresses:** `i_v`=15'h2C45, sel=1, NT data 8'h7A → addresses 14'h2C45, 14'h2FC1, 14'h17A2, 14'h17AA on cycles 1-2, 3-4, 5-6, 7-8.
- **Attribute select:** same tile with AT data 8'hB4 → `o_attribute`=8'h03 with the macro, 8'hB4 without. PT data 8'h55/8'hAA → `o_pattern_lo`=8'h55, `o_pattern_hi`=8'hAA, `o_tile_valid` on cycle 9.
- **Back-to-back:** `i_fetch_en` held for 34 cycles, bench incrementing coarse X on `o_inc_x` → 4 tiles, `o_inc_x` on cycles 8, 16, 24, 32. NT addresses 14'h2C45, 14'h2C46, 14'h2C47, 14'h2C48 with no idle gap.
- **Abort:** drop `i_fetch_en` on cycle 6 → IDLE on cycle 7, no `o_inc_x`, no `o_tile_valid`, outputs unchanged from the prior tile.
- **Parameter:** `CYCLES_PER_FETCH`=1 → 4-cycle tile, `o_read` every cycle, `o_tile_valid` on cycle 5.
